// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stall/flush controls and status out.
// The pipeline side drives through master; the controller sits on slave.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_muldiv;
  logic              ex_isdiv;
  logic              mem_req;
  logic              mem_ack;
  logic              branch_taken;

  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_hold;
  logic              idex_flush;
  logic              exmem_hold;
  logic              exmem_flush;
  logic              memwb_flush;
  logic [1:0]        state;
  logic [31:0]       stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_muldiv, ex_isdiv,
           mem_req, mem_ack, branch_taken,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
           exmem_hold, exmem_flush, memwb_flush, state, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_muldiv, ex_isdiv,
           mem_req, mem_ack, branch_taken,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
           exmem_hold, exmem_flush, memwb_flush, state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mul/div EX occupancy,
// data-memory wait and branch redirect, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);
  // state  | meaning
  // RUN    | normal flow; a multi-cycle mul/div in EX is its first busy cycle
  // EXBUSY | mul/div still occupying EX; cnt = remaining busy cycles after this one
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EXBUSY = 2'd1
  } state_t;

  localparam logic MUL_MULTI = (MUL_LAT > 1);
  localparam logic DIV_MULTI = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_q;
  logic [REG_AW-1:0] reg_zero;

  logic memstall, multi, exbusy, load_use, rd_match;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
  logic exmem_hold, exmem_flush, memwb_flush;

  assign reg_zero = '0;
  assign memstall = bus.mem_req & ~bus.mem_ack;
  assign multi    = bus.ex_muldiv & (bus.ex_isdiv ? DIV_MULTI : MUL_MULTI);
  assign exbusy   = ((state_q == EXBUSY) && (cnt_q != '0)) || ((state_q == RUN) && multi);
  assign rd_match = (bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt));
  assign load_use = (state_q == RUN) && bus.ex_memread && (bus.ex_rd != reg_zero) && rd_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pc_hold) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (multi && !memstall) begin
          state_d = EXBUSY;
          cnt_d   = bus.ex_isdiv ? DIV_LOAD : MUL_LOAD;
        end
      end
      EXBUSY: begin
        // countdown continues under memstall; only the exit waits for it
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (!memstall) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      if (memstall) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_hold  = 1'b1;
        memwb_flush = 1'b1;
      end else if (exbusy) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_flush = 1'b1;
      end else if (bus.branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_flush  = 1'b1;
      end
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.ifid_hold    = ifid_hold;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_hold    = idex_hold;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_hold   = exmem_hold;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_flush  = memwb_flush;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives hold and flush for the PC and for the four pipe registers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves four events: load-use hazards, multi-cycle mul/div occupancy of EX, data-memory wait, and taken-branch redirect.
- Its outputs feed the hold inputs of the pipe registers and the bubble-insert (flush) muxes in front of them.
- Also keeps a stall-cycle performance counter.

Parameters:
- REG_AW, 5, register-address width.
- MUL_LAT, 3, EX cycles a multiply occupies (≥1).
- DIV_LAT, 32, EX cycles a divide occupies (≥1).
- CNT_W, 6, busy-counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs_i  in  REG_AW  rs field of the instruction in ID.
- id_rt_i  in  REG_AW  rt field of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rd_i  in  REG_AW  destination register of the EX instruction.
- ex_muldiv_i  in  1  EX instruction is a mul/div.
- ex_isdiv_i  in  1  qualifies ex_muldiv_i: 1 = divide.
- mem_req_i  in  1  MEM stage has a data access in flight.
- mem_ack_i  in  1  data access completes this cycle.
- branch_taken_i  in  1  branch resolved taken in EX.
- pc_hold_o  out  1  freeze PC.
- ifid_hold_o  out  1  hold IF/ID.
- ifid_flush_o  out  1  load bubble into IF/ID.
- idex_hold_o  out  1  hold ID/EX.
- idex_flush_o  out  1  load bubble into ID/EX.
- exmem_hold_o  out  1  hold EX/MEM.
- exmem_flush_o  out  1  load bubble into EX/MEM.
- memwb_flush_o  out  1  load bubble into MEM/WB.
- state_o  out  2  0 = RUN, 1 = EXBUSY.
- stall_cycles_o  out  32  count of cycles with pc_hold_o = 1.

Behaviour:
- **Reset.** While rst_i = 1, all hold and flush outputs are 0. Asynchronous reset forces state = RUN, busy counter = 0 and stall_cycles_o = 0. Reset mid-stall abandons the stall; the first cycle after release is RUN with no holds.
- **Output timing.** Hold/flush outputs are combinational from the current state, the counter and the inputs. The state, counter and perf counter are registered.
- **Term memstall** = mem_req_i & ~mem_ack_i.
  - Asserts pc/ifid/idex/exmem hold and memwb_flush.
  - The stall releases in the same cycle that mem_ack_i rises.
- **Term exbusy** = (state == EXBUSY) & (cnt != 0).
  - Asserts pc/ifid/idex hold and exmem_flush.
- **State machine.**
  - RUN → EXBUSY at an edge where ex_muldiv_i = 1, the selected latency L > 1 and memstall = 0. On that edge cnt loads L-2; this first cycle itself is the first busy cycle, so exbusy is also asserted combinationally in RUN when ex_muldiv_i & L > 1.
  - In EXBUSY: cnt decrements every cycle until it reaches 0, including during memstall.
  - EXBUSY → RUN at an edge where cnt == 0 and memstall = 0. The mul/div therefore occupies EX for exactly L cycles when there is no memstall.
  - A mul/div with L = 1 never leaves RUN.
  - Back-to-back mul/div instructions re-enter EXBUSY on the next cycle.
- **Load-use** (RUN only, not exbusy): ex_memread_i & ex_rd_i ≠ 0 & (ex_rd_i == id_rs_i | (id_uses_rt_i & ex_rd_i == id_rt_i)).
  - Asserts pc_hold, ifid_hold and idex_flush for one cycle.
  - Register 0 never triggers a load-use stall.
- **Branch.** When branch_taken_i = 1 and memstall = 0: assert ifid_flush and idex_flush. This cancels a simultaneous load-use stall, so pc_hold and ifid_hold stay 0.
- **Priority.** memstall > exbusy > branch > load-use.
  - A hold on a register always overrides a flush on the same register.
  - A branch seen during memstall is deferred; EX is held, so branch_taken_i stays asserted and is acted on in the release cycle.
- **Perf counter.** stall_cycles_o increments on every edge where pc_hold_o = 1 and wraps from 2^32-1 to 0.

Test Plan:
- **Load-use.** ex_memread = 1, ex_rd = 5, id_rs = 5 → pc/ifid hold and idex_flush high for exactly 1 cycle. Repeat with ex_rd = 0 → no stall.
- **Multiply.** ex_muldiv = 1, isdiv = 0, MUL_LAT = 3 → holds high for cycles 0–1, released in cycle 2; state_o returns to 0; stall_cycles_o += 2.
- **Divide with memstall.** DIV_LAT = 32 divide, plus a 5-cycle memstall starting in busy cycle 30 → cnt reaches 0 but holds persist until mem_ack; total hold = 35 cycles; exmem_hold wins over exmem_flush.
- **Branch vs load-use.** branch_taken = 1 together with a load-use match → ifid_flush = idex_flush = 1, pc_hold = 0.
- **Async reset.** rst_i pulsed mid-divide (cnt = 17) → outputs immediately 0; after release state_o = 0 and stall_cycles_o = 0.
- **Counter wrap.** Preload stall_cycles_o = 0xFFFFFFFF (via force), then one stall cycle → counter reads 0.
